ofdm_cp_strip_s2p: RTL
======================

Name: ofdm_cp_strip_s2p

Overview:
Upstream feeder for the 16-point parallel FFT core in the OFDM receive chain. Takes the serial complex sample stream and a start-of-symbol marker, discards the cyclic prefix, and collects FFT_SIZE samples in natural order. It then presents them as one parallel word set with a single-cycle enable that drives the FFT's en input. Output registers are double-buffered so the next symbol can be collected while the FFT consumes the current one.

Parameters:
WIDTH, 16, bit width of each real/imag sample (signed two's complement)
FFT_SIZE, 16, samples per OFDM symbol body (power of two, 2..64)
CP_LEN, 4, cyclic-prefix samples discarded per symbol (0..FFT_SIZE)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  qualifies in_sof/in_real/in_imag this cycle
in_sof  input  1  first sample (first CP sample) of a symbol; ignored when in_valid=0
in_real  input  WIDTH  signed sample, real part
in_imag  input  WIDTH  signed sample, imag part
fft_en  output  1  one-cycle pulse: parallel outputs hold a new symbol (drives FFT en)
x_real_flat  output  FFT_SIZE*WIDTH  sample n at [n*WIDTH +: WIDTH], natural order
x_imag_flat  output  FFT_SIZE*WIDTH  same packing, imag parts
sym_abort  output  1  one-cycle pulse: partial symbol dropped due to early in_sof
busy  output  1  high while state is SKIP or COLLECT

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, shadow and output registers 0, fft_en=0, sym_abort=0, busy=0.
- Counter cnt width clog2(FFT_SIZE+CP_LEN)+1; advances only on in_valid=1 cycles. Gaps in in_valid stall without effect.
- IDLE: on in_valid&in_sof: if CP_LEN>0, go to SKIP with cnt=1 (sof sample counted as CP sample 0). If CP_LEN=0, store the sample at shadow[0] and go to COLLECT with cnt=1. Valid samples without sof are dropped.
- SKIP: each valid sample increments cnt. When the CP_LEN-th CP sample is consumed, go to COLLECT with cnt=0.
- COLLECT: each valid sample is written to shadow[cnt], then cnt increments. On the FFT_SIZE-th sample (cnt==FFT_SIZE-1), all shadow entries plus the current sample are copied to the output registers on that clock edge. fft_en=1 the following cycle, for exactly one cycle. State then returns to IDLE.
- Latency: the clock edge after the last body sample's valid cycle shows the new x_*_flat with fft_en=1. The outputs hold until the next completed symbol; they are never altered by partial symbols or aborts.
- Back-to-back: an in_sof arriving in the cycle right after the last body sample is accepted by IDLE normally. Zero-gap symbol streams must be supported.
- Early in_sof: in_valid&in_sof while in SKIP or COLLECT drops the partial symbol and pulses sym_abort=1 for one cycle. The sof sample restarts the symbol exactly as the IDLE rule above. Shadow contents need not be cleared.
- in_sof on the last body sample: treated as early sof. The symbol is aborted, no fft_en, and a restart follows.
- No arithmetic: samples pass bit-exact, no scaling or sign change.
- busy: combinational decode of state (1 in SKIP/COLLECT).

Optional Feature:
Macro OFDM_S2P_STATS_EN.
- Defined: two extra outputs, sym_count (16 bits) and abort_count (16 bits). sym_count increments on every fft_en pulse; abort_count increments on every sym_abort pulse. Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream after 7 COLLECT samples -> all outputs 0 immediately, busy=0. After release, the next valid non-sof samples are ignored.
- Nominal, CP_LEN=4: sof + 20 consecutive valid samples, real=1..20, imag=-1..-20 -> exactly one fft_en pulse, on the cycle after sample 20. x0_real=5 ... x15_real=20, x15_imag=-20.
- Valid gaps: same 20 samples with in_valid=0 inserted every other cycle -> identical outputs, fft_en one cycle after the 20th valid sample.
- Early sof: sof + 10 samples, then sof + 20 samples (values 101..120) -> sym_abort pulse on the cycle after the second sof. One fft_en follows, with x0_real=105, x15_real=120. Previous outputs stay held until then.
- Back-to-back: three symbols of 20 samples with no idle cycles -> three fft_en pulses spaced 20 cycles apart, each with the correct data. busy stays high except for the single cycle after each final sample.
- CP_LEN=0 build with OFDM_S2P_STATS_EN: two clean symbols and one aborted symbol -> sym_count=2, abort_count=1. The sof sample lands in x0.

Source files
------------

// File: rtl/ofdm_cp_strip_s2p_if.sv
// ofdm_cp_strip_s2p_if: sample-stream in / parallel-symbol out bus for the
// cyclic-prefix stripper and serial-to-parallel feeder of the 16-point FFT.
//   in_valid, in_sof, in_real, in_imag : serial complex sample stream
//   fft_en, x_real_flat, x_imag_flat   : parallel symbol and its enable pulse
//   sym_abort, busy                    : status
//   sym_count, abort_count             : only when OFDM_S2P_STATS_EN is defined
// Modports: master drives the stream (testbench / upstream), slave is the block.
interface ofdm_cp_strip_s2p_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FFT_SIZE = 16
);
    logic                      in_valid;
    logic                      in_sof;
    logic signed [WIDTH-1:0]   in_real;
    logic signed [WIDTH-1:0]   in_imag;
    logic                      fft_en;
    logic [FFT_SIZE*WIDTH-1:0] x_real_flat;
    logic [FFT_SIZE*WIDTH-1:0] x_imag_flat;
    logic                      sym_abort;
    logic                      busy;
`ifdef OFDM_S2P_STATS_EN
    logic [15:0]               sym_count;
    logic [15:0]               abort_count;
`endif

    modport master (
        output in_valid, in_sof, in_real, in_imag,
        input  fft_en, x_real_flat, x_imag_flat, sym_abort, busy
`ifdef OFDM_S2P_STATS_EN
        , input sym_count, abort_count
`endif
    );

    modport slave (
        input  in_valid, in_sof, in_real, in_imag,
        output fft_en, x_real_flat, x_imag_flat, sym_abort, busy
`ifdef OFDM_S2P_STATS_EN
        , output sym_count, abort_count
`endif
    );
endinterface

// File: rtl/ofdm_cp_strip_s2p.sv
// ofdm_cp_strip_s2p: drops the cyclic prefix of each OFDM symbol, gathers
// FFT_SIZE body samples in natural order and presents them as one parallel
// word set with a one-cycle fft_en. The output registers are loaded only on a
// completed symbol, so the next symbol collects into the shadow while the FFT
// works on the current one.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ofdm_cp_strip_s2p_if.slave (stream in, parallel symbol/status out)
// Optional: define OFDM_S2P_STATS_EN to add saturating 16-bit sym_count and
// abort_count outputs on the bus.
module ofdm_cp_strip_s2p #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FFT_SIZE = 16,
    parameter int unsigned CP_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ofdm_cp_strip_s2p_if.slave   bus
);
    localparam int unsigned CNT_W  = $clog2(FFT_SIZE + CP_LEN) + 1;
    localparam int unsigned SH_N   = FFT_SIZE - 1;
    localparam int unsigned FLAT_W = FFT_SIZE * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_COLLECT
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    // Last body sample goes straight to the outputs, so only FFT_SIZE-1 shadow slots.
    logic [SH_N-1:0][WIDTH-1:0] sh_re_q, sh_re_d;
    logic [SH_N-1:0][WIDTH-1:0] sh_im_q, sh_im_d;
    logic [FLAT_W-1:0]          x_re_q, x_re_d;
    logic [FLAT_W-1:0]          x_im_q, x_im_d;
    logic                       fft_en_q, fft_en_d;
    logic                       abort_q, abort_d;
`ifdef OFDM_S2P_STATS_EN
    logic [15:0]                sym_cnt_q, sym_cnt_d;
    logic [15:0]                abort_cnt_q, abort_cnt_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sh_re_q  <= '0;
            sh_im_q  <= '0;
            x_re_q   <= '0;
            x_im_q   <= '0;
            fft_en_q <= 1'b0;
            abort_q  <= 1'b0;
`ifdef OFDM_S2P_STATS_EN
            sym_cnt_q   <= '0;
            abort_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_re_q  <= sh_re_d;
            sh_im_q  <= sh_im_d;
            x_re_q   <= x_re_d;
            x_im_q   <= x_im_d;
            fft_en_q <= fft_en_d;
            abort_q  <= abort_d;
`ifdef OFDM_S2P_STATS_EN
            sym_cnt_q   <= sym_cnt_d;
            abort_cnt_q <= abort_cnt_d;
`endif
        end
    end

    // Next-state, counter, shadow and output-register update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_re_d  = sh_re_q;
        sh_im_d  = sh_im_q;
        x_re_d   = x_re_q;
        x_im_d   = x_im_q;
        fft_en_d = 1'b0;
        abort_d  = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // sof always (re)starts a symbol; mid-symbol it drops the partial one.
                abort_d = (state_q != S_IDLE);
                if (CP_LEN == 0) begin
                    sh_re_d[0] = bus.in_real;
                    sh_im_d[0] = bus.in_imag;
                    state_d    = S_COLLECT;
                    cnt_d      = CNT_W'(1);
                end else if (CP_LEN == 1) begin
                    // The sof sample is the whole prefix.
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_SKIP;
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                case (state_q)
                    S_SKIP: begin
                        if ((cnt_q + CNT_W'(1)) == CNT_W'(CP_LEN)) begin
                            state_d = S_COLLECT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_COLLECT: begin
                        if (cnt_q == CNT_W'(FFT_SIZE - 1)) begin
                            // Shadow (element 0 in the LSBs) plus the live sample form the symbol.
                            x_re_d   = {bus.in_real, sh_re_q};
                            x_im_d   = {bus.in_imag, sh_im_q};
                            fft_en_d = 1'b1;
                            state_d  = S_IDLE;
                            cnt_d    = '0;
                        end else begin
                            for (int i = 0; i < int'(SH_N); i++) begin
                                if (cnt_q == CNT_W'(i)) begin
                                    sh_re_d[i] = bus.in_real;
                                    sh_im_d[i] = bus.in_imag;
                                end
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef OFDM_S2P_STATS_EN
    // Saturating event counters, updated on the same edge as their pulses.
    always_comb begin
        sym_cnt_d   = sym_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (fft_en_d && (sym_cnt_q != 16'hFFFF)) begin
            sym_cnt_d = sym_cnt_q + 16'd1;
        end
        if (abort_d && (abort_cnt_q != 16'hFFFF)) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
        end
    end

    assign bus.sym_count   = sym_cnt_q;
    assign bus.abort_count = abort_cnt_q;
`endif

    assign bus.fft_en      = fft_en_q;
    assign bus.sym_abort   = abort_q;
    assign bus.x_real_flat = x_re_q;
    assign bus.x_imag_flat = x_im_q;
    assign bus.busy        = (state_q == S_SKIP) || (state_q == S_COLLECT);
endmodule
